// File: rtl/writeback_arbiter.sv
// writeback_arbiter: N-channel register-file writeback arbiter.
// Each producer channel feeds its own FIFO. One FIFO head is popped per cycle
// by round-robin, and the popped entry drives a registered register-file write port.
// Writes to x0 and non-writing entries are consumed without raising rd_load.
// Optional build macro WRITEBACK_FORWARD_EN adds a combinational view of the
// entry being popped (fwd_valid/fwd_addr/fwd_data) for the decode bypass.
module writeback_arbiter #(
    parameter int NCHAN = 2,
    parameter int DEPTH = 4,
    parameter int XLEN  = 32,
    parameter int AW    = 5
) (
    input  logic                                  aclk,
    input  logic                                  aresetn,
    input  logic [NCHAN-1:0]                      s_tvalid,
    output logic [NCHAN-1:0]                      s_tready,
    input  logic [NCHAN-1:0]                      s_we,
    input  logic [NCHAN*AW-1:0]                   s_addr,
    input  logic [NCHAN*XLEN-1:0]                 s_data,
    output logic                                  rd_load,
    output logic [AW-1:0]                         rd_addr,
    output logic [XLEN-1:0]                       rd_data,
    output logic [NCHAN*($clog2(DEPTH)+1)-1:0]    level,
    output logic                                  busy
`ifdef WRITEBACK_FORWARD_EN
    ,
    output logic                                  fwd_valid,
    output logic [AW-1:0]                         fwd_addr,
    output logic [XLEN-1:0]                       fwd_data
`endif
);

    localparam int PW = $clog2(DEPTH);            // FIFO pointer width
    localparam int LW = PW + 1;                   // occupancy width (0..DEPTH)
    localparam int EW = 1 + AW + XLEN;            // stored entry {we, addr, data}
    localparam int GW = (NCHAN > 1) ? $clog2(NCHAN) : 1;

    logic [EW-1:0]    head [NCHAN];
    logic [NCHAN-1:0] not_empty;
    logic [NCHAN-1:0] push;
    logic [NCHAN-1:0] pop;

    logic             grant_valid;
    logic [GW-1:0]    grant_idx;
    logic [GW-1:0]    cand_idx;
    logic [GW-1:0]    rr_q, rr_d;

    logic [EW-1:0]    head_sel;
    logic             head_we;
    logic [AW-1:0]    head_addr;
    logic [XLEN-1:0]  head_data;

    logic             rd_load_q, rd_load_d;
    logic [AW-1:0]    rd_addr_q, rd_addr_d;
    logic [XLEN-1:0]  rd_data_q, rd_data_d;

    // Per-channel FIFOs. Ready depends only on the registered count, so a full
    // FIFO refuses a beat even in a cycle where its head is popped.
    for (genvar gi = 0; gi < NCHAN; gi++) begin : g_chan
        logic [EW-1:0] mem [DEPTH];
        logic [PW-1:0] wr_ptr_q, wr_ptr_d;
        logic [PW-1:0] rd_ptr_q, rd_ptr_d;
        logic [LW-1:0] cnt_q, cnt_d;

        assign s_tready[gi]          = (cnt_q != LW'(DEPTH));
        assign push[gi]              = s_tvalid[gi] & s_tready[gi];
        assign not_empty[gi]         = (cnt_q != '0);
        assign pop[gi]               = grant_valid & (grant_idx == GW'(gi));
        assign head[gi]              = mem[rd_ptr_q];
        assign level[gi*LW +: LW]    = cnt_q;

        // Pointer and occupancy update; pointers wrap naturally at DEPTH.
        always_comb begin
            wr_ptr_d = wr_ptr_q + PW'(push[gi]);
            rd_ptr_d = rd_ptr_q + PW'(pop[gi]);
            cnt_d    = cnt_q + LW'(push[gi]) - LW'(pop[gi]);
        end

        // Pointer and occupancy registers; reset empties the FIFO.
        always_ff @(posedge aclk or negedge aresetn) begin
            if (!aresetn) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                cnt_q    <= '0;
            end else begin
                wr_ptr_q <= wr_ptr_d;
                rd_ptr_q <= rd_ptr_d;
                cnt_q    <= cnt_d;
            end
        end

        // Entry storage; contents need no reset because the count gates them.
        always_ff @(posedge aclk) begin
            if (push[gi]) begin
                mem[wr_ptr_q] <= {s_we[gi], s_addr[gi*AW +: AW], s_data[gi*XLEN +: XLEN]};
            end
        end
    end

    // Round-robin search: scanning from farthest to nearest lets the first
    // non-empty channel after the pointer win.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand_idx    = '0;
        for (int k = NCHAN; k >= 1; k--) begin
            cand_idx = GW'((int'(rr_q) + k) % NCHAN);
            if (not_empty[cand_idx]) begin
                grant_valid = 1'b1;
                grant_idx   = cand_idx;
            end
        end
    end

    assign head_sel  = head[grant_idx];
    assign head_we   = head_sel[EW-1];
    assign head_addr = head_sel[XLEN +: AW];
    assign head_data = head_sel[XLEN-1:0];

    // Output-stage next state: load only for real writes to a non-zero register,
    // address/data follow every pop and hold otherwise.
    always_comb begin
        rr_d      = grant_valid ? grant_idx : rr_q;
        rd_load_d = grant_valid & head_we & (head_addr != '0);
        rd_addr_d = grant_valid ? head_addr : rd_addr_q;
        rd_data_d = grant_valid ? head_data : rd_data_q;
    end

    // Arbiter pointer and write-port registers; pointer resets so channel 0 wins first.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rr_q      <= GW'(NCHAN - 1);
            rd_load_q <= 1'b0;
            rd_addr_q <= '0;
            rd_data_q <= '0;
        end else begin
            rr_q      <= rr_d;
            rd_load_q <= rd_load_d;
            rd_addr_q <= rd_addr_d;
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_load = rd_load_q;
    assign rd_addr = rd_addr_q;
    assign rd_data = rd_data_q;
    assign busy    = (|level) | rd_load_q;

`ifdef WRITEBACK_FORWARD_EN
    // Early view of the write that will appear on the port next cycle.
    assign fwd_valid = rd_load_d;
    assign fwd_addr  = head_addr;
    assign fwd_data  = head_data;
`endif

endmodule
